// File: rtl/cache_fill_fsm.sv
// Cache-miss block fill controller: issues one word read per cycle for the
// aligned block and streams in-order responses into the cache data array.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_detected,
    input  logic [ADDR_WIDTH-1:0]          miss_address,
    output logic                           fsm_busy,
    output logic                           mem_en,
    output logic [ADDR_WIDTH-1:0]          memory_address,
    input  logic [15:0]                    memory_data,
    input  logic                           memory_data_valid,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic [15:0]                    fill_data,
    output logic                           write_tag_array
);

    localparam int WW = $clog2(BLOCK_WORDS);
    localparam int CW = WW + 1;
    localparam logic [CW-1:0] BW_C   = CW'(BLOCK_WORDS);
    localparam logic [CW-1:0] LAST_C = CW'(BLOCK_WORDS - 1);
    // Clears the word offset and the byte-select bit.
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'((1 << (WW + 1)) - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   base_reg, base_next;
    logic [CW-1:0]           req_cnt_reg, req_cnt_next;
    logic [CW-1:0]           rsp_cnt_reg, rsp_cnt_next;
    logic [CW-1:0]           req_issued;
    logic                    accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            base_reg    <= '0;
            req_cnt_reg <= '0;
            rsp_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            base_reg    <= base_next;
            req_cnt_reg <= req_cnt_next;
            rsp_cnt_reg <= rsp_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        base_next        = base_reg;
        req_cnt_next     = req_cnt_reg;
        rsp_cnt_next     = rsp_cnt_reg;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = base_reg;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_word        = '0;
        req_issued       = req_cnt_reg;
        accept           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (miss_detected) begin
                    state_next   = FILL;
                    base_next    = miss_address & BASE_MASK;
                    req_cnt_next = '0;
                    rsp_cnt_next = '0;
                end
            end
            FILL: begin
                fsm_busy       = 1'b1;
                mem_en         = (req_cnt_reg < BW_C);
                memory_address = base_reg + ADDR_WIDTH'({req_cnt_reg, 1'b0});
                if (mem_en) begin
                    req_cnt_next = req_cnt_reg + 1'b1;
                end
                // A zero-latency response may answer the request issued this cycle.
                req_issued = req_cnt_reg + CW'(mem_en);
                accept     = memory_data_valid && (rsp_cnt_reg < req_issued);
                if (accept) begin
                    write_data_array = 1'b1;
                    fill_word        = rsp_cnt_reg[WW-1:0];
                    rsp_cnt_next     = rsp_cnt_reg + 1'b1;
                    if (rsp_cnt_reg == LAST_C) begin
                        write_tag_array = 1'b1;
                        state_next      = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign fill_data = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized bench for cache_fill_fsm: an in-order latency memory model with a
// request queue predicts every request address, write, tag pulse and busy span.
module tb_cache_fill_fsm;

    localparam int AW = 16;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          miss_detected = 1'b0;
    logic [AW-1:0] miss_address = '0;
    logic          fsm_busy;
    logic          mem_en;
    logic [AW-1:0] memory_address;
    logic [15:0]   memory_data = '0;
    logic          memory_data_valid = 1'b0;
    logic          write_data_array;
    logic [2:0]    fill_word;
    logic [15:0]   fill_data;
    logic          write_tag_array;

    int total = 0;
    int bad   = 0;
    int req_q[$];

    cache_fill_fsm #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .fsm_busy         (fsm_busy),
        .mem_en           (mem_en),
        .memory_address   (memory_address),
        .memory_data      (memory_data),
        .memory_data_valid(memory_data_valid),
        .write_data_array (write_data_array),
        .fill_word        (fill_word),
        .fill_data        (fill_data),
        .write_tag_array  (write_tag_array)
    );

    always #5 clk = ~clk;

    // gap: 0 = valid whenever the head response is due, 1 = only on odd cycles,
    // 2 = random. stop_after < BW returns early once that many words are written.
    task automatic run_fill(input logic [AW-1:0] addr, input int lat, input int gap,
                            input bit hold, input bit started, input logic [AW-1:0] next_addr,
                            input int stop_after, input string name);
        logic [AW-1:0] base_exp;
        logic [AW-1:0] addr_exp;
        int  nreq, nwr, ntag, busy_cycles;
        bit  done, v;
        base_exp    = addr & 16'hFFF0;
        nreq        = 0;
        nwr         = 0;
        ntag        = 0;
        busy_cycles = 0;
        done        = 1'b0;
        req_q.delete();
        if (!started) begin
            @(negedge clk);
            miss_detected     = 1'b1;
            miss_address      = addr;
            memory_data_valid = 1'b0;
        end
        for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (hold) miss_address = AW'($urandom);
            else      miss_detected = 1'b0;
            if (stop_after < BW && nwr == stop_after) begin
                done = 1'b1;
            end else if (nwr == BW) begin
                memory_data_valid = 1'($urandom % 2);
                memory_data       = 16'($urandom);
                #1;
                total++;
                if (fsm_busy !== 1'b0 || mem_en !== 1'b0 || write_data_array !== 1'b0 ||
                    write_tag_array !== 1'b0 || fill_word !== 3'd0 || memory_address !== base_exp) begin
                    bad++;
                    $display("FAIL %s idle cyc=%0d got busy=%b en=%b wd=%b wt=%b fw=%0d addr=%h want 0 0 0 0 0 %h",
                             name, cyc, fsm_busy, mem_en, write_data_array, write_tag_array,
                             fill_word, memory_address, base_exp);
                end
                if (hold) miss_address = next_addr;
                done = 1'b1;
            end else begin
                busy_cycles++;
                if (nreq < BW) req_q.push_back(cyc);
                v = 1'b0;
                if (req_q.size() > 0 && req_q[0] + lat <= cyc &&
                    (gap == 0 || (gap == 1 && (cyc % 2) == 1) || (gap == 2 && ($urandom % 2) == 1)))
                    v = 1'b1;
                memory_data_valid = v;
                memory_data       = 16'($urandom);
                #1;
                addr_exp = base_exp + AW'(2 * nreq);
                total++;
                if (fsm_busy !== 1'b1 || mem_en !== (nreq < BW) ||
                    (nreq < BW && memory_address !== addr_exp)) begin
                    bad++;
                    $display("FAIL %s req cyc=%0d got busy=%b en=%b addr=%h want 1 %b %h",
                             name, cyc, fsm_busy, mem_en, memory_address, (nreq < BW), addr_exp);
                end
                total++;
                if (write_data_array !== v) begin
                    bad++;
                    $display("FAIL %s wr cyc=%0d got %b want %b", name, cyc, write_data_array, v);
                end
                total++;
                if (v) begin
                    if (fill_word !== 3'(nwr) || fill_data !== memory_data ||
                        write_tag_array !== (nwr == BW - 1)) begin
                        bad++;
                        $display("FAIL %s word cyc=%0d got fw=%0d fd=%h wt=%b want %0d %h %b",
                                 name, cyc, fill_word, fill_data, write_tag_array, nwr,
                                 memory_data, (nwr == BW - 1));
                    end
                end else if (write_tag_array !== 1'b0) begin
                    bad++;
                    $display("FAIL %s tag cyc=%0d got %b want 0", name, cyc, write_tag_array);
                end
                if (write_tag_array === 1'b1) ntag++;
                if (v) begin
                    void'(req_q.pop_front());
                    nwr++;
                end
                if (nreq < BW) nreq++;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s timeout got writes=%0d want %0d", name, nwr, BW);
        end else if (stop_after >= BW) begin
            total++;
            if (ntag != 1) begin
                bad++;
                $display("FAIL %s tag_count got %0d want 1", name, ntag);
            end
            if (gap == 0) begin
                total++;
                if (busy_cycles != BW + lat) begin
                    bad++;
                    $display("FAIL %s busy_len got %0d want %0d", name, busy_cycles, BW + lat);
                end
            end
        end
        if (!hold) memory_data_valid = 1'b0;
    endtask

    task automatic check_zero(input string name);
        total++;
        if (fsm_busy !== 1'b0 || mem_en !== 1'b0 || write_data_array !== 1'b0 ||
            write_tag_array !== 1'b0 || fill_word !== 3'd0 || memory_address !== 16'h0000) begin
            bad++;
            $display("FAIL %s got busy=%b en=%b wd=%b wt=%b fw=%0d addr=%h want all 0",
                     name, fsm_busy, mem_en, write_data_array, write_tag_array, fill_word, memory_address);
        end
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        miss_detected     = 1'b1;
        miss_address      = 16'h1236;
        memory_data_valid = 1'b1;
        memory_data       = 16'hBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n             = 1'b1;
        miss_detected     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("reset_idle_valid");
        memory_data_valid = 1'b0;
    endtask

    task automatic test_basic();
        run_fill(16'h1236, 0, 0, 1'b0, 1'b0, 16'h0, BW, "basic");
    endtask

    task automatic test_latency();
        run_fill(16'h0040, 3, 0, 1'b0, 1'b0, 16'h0, BW, "lat3");
    endtask

    task automatic test_gapped();
        run_fill(16'h0A5E, 0, 1, 1'b0, 1'b0, 16'h0, BW, "gap0");
        run_fill(16'h7712, 2, 1, 1'b0, 1'b0, 16'h0, BW, "gap2");
    endtask

    task automatic test_back_to_back();
        run_fill(16'hFFF4, 0, 0, 1'b1, 1'b0, 16'h2468, BW, "b2b_first");
        run_fill(16'h2468, 1, 0, 1'b0, 1'b1, 16'h0, BW, "b2b_second");
    endtask

    task automatic test_mid_reset();
        run_fill(16'h3000, 0, 0, 1'b0, 1'b0, 16'h0, 3, "mid_pre");
        rst_n             = 1'b0;
        miss_detected     = 1'b1;
        memory_data_valid = 1'b1;
        #1;
        check_zero("mid_reset_now");
        @(posedge clk);
        @(negedge clk);
        check_zero("mid_reset_hold");
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        rst_n             = 1'b1;
        run_fill(16'h5556, 0, 0, 1'b0, 1'b0, 16'h0, BW, "mid_after");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_fill(AW'($urandom), int'($urandom_range(0, 4)), 2, 1'b0, 1'b0, 16'h0, BW, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_gapped();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
